// File: rtl/playback_scheduler_pkg.sv
// Shared types and defaults for the USB-to-I2S playback scheduler.
package playback_scheduler_pkg;

  localparam int LEVEL_W_DEF     = 10;
  localparam int START_LEVEL_DEF = 256;
  localparam int CNT_W_DEF       = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PREFILL = 2'd1,
    ST_PLAY    = 2'd2
  } state_t;

  function automatic logic is_streaming(input state_t s);
    return (s == ST_PREFILL) || (s == ST_PLAY);
  endfunction

endpackage

// File: rtl/playback_scheduler_if.sv
// Control/status bundle between the sample-path controller and the scheduler.
interface playback_scheduler_if #(
  parameter int LEVEL_W = 10,
  parameter int CNT_W   = 16
) ();
  logic               enable;
  logic               cnt_clear;
  logic               sample_valid;
  logic               sample_tick;
  logic [LEVEL_W-1:0] fifo_level;
  logic               fifo_full;
  logic               fifo_empty;
  logic               wr_en;
  logic               rd_en;
  logic               fifo_flush;
  logic               mute;
  logic [1:0]         state;
  logic [CNT_W-1:0]   underrun_cnt;
  logic [CNT_W-1:0]   overrun_cnt;

  modport master (
    output enable, cnt_clear, sample_valid, sample_tick,
           fifo_level, fifo_full, fifo_empty,
    input  wr_en, rd_en, fifo_flush, mute, state, underrun_cnt, overrun_cnt
  );

  modport slave (
    input  enable, cnt_clear, sample_valid, sample_tick,
           fifo_level, fifo_full, fifo_empty,
    output wr_en, rd_en, fifo_flush, mute, state, underrun_cnt, overrun_cnt
  );
endinterface

// File: rtl/playback_scheduler_sat_counter.sv
// Saturating event counter; clear wins over a same-cycle increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] count
);
  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {CNT_W{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;
endmodule

// File: rtl/playback_scheduler.sv
// Gates FIFO writes/reads around a prefill threshold, mutes playback until
// the buffer is primed, and counts underruns/overruns.
module playback_scheduler
  import playback_scheduler_pkg::*;
#(
  parameter int LEVEL_W     = LEVEL_W_DEF,
  parameter int START_LEVEL = START_LEVEL_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input logic                 clk,
  input logic                 rst,
  playback_scheduler_if.slave bus
);
  // One extra bit so a threshold equal to the FIFO depth is still representable.
  localparam logic [LEVEL_W:0] START_THR = (LEVEL_W + 1)'(START_LEVEL);

  state_t state_reg;
  logic   wr_en_reg;
  logic   rd_en_reg;
  logic   flush_reg;
  logic   mute_reg;

  logic level_ok;
  logic write_ok;
  logic active;
  logic underrun_inc;
  logic overrun_inc;
  logic [CNT_W-1:0] underrun_count;
  logic [CNT_W-1:0] overrun_count;

  assign level_ok = ({1'b0, bus.fifo_level} >= START_THR);
  assign write_ok = bus.sample_valid && !bus.fifo_full;
  // A falling enable takes priority: nothing is written, read or counted that cycle.
  assign active   = is_streaming(state_reg) && bus.enable;

  assign underrun_inc = active && (state_reg == ST_PLAY) && bus.sample_tick && bus.fifo_empty;
  // Both flags at once is treated as empty, so no overrun is charged.
  assign overrun_inc  = active && bus.sample_valid && bus.fifo_full && !bus.fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      wr_en_reg <= 1'b0;
      rd_en_reg <= 1'b0;
      flush_reg <= 1'b0;
      mute_reg  <= 1'b1;
    end else begin
      wr_en_reg <= 1'b0;
      rd_en_reg <= 1'b0;
      flush_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          mute_reg <= 1'b1;
          if (bus.enable) state_reg <= ST_PREFILL;
        end
        ST_PREFILL: begin
          mute_reg <= 1'b1;
          if (!bus.enable) begin
            state_reg <= ST_IDLE;
            flush_reg <= 1'b1;
          end else begin
            wr_en_reg <= write_ok;
            if (bus.sample_tick && level_ok && !bus.fifo_empty) begin
              state_reg <= ST_PLAY;
              rd_en_reg <= 1'b1;
              mute_reg  <= 1'b0;
            end
          end
        end
        ST_PLAY: begin
          if (!bus.enable) begin
            state_reg <= ST_IDLE;
            flush_reg <= 1'b1;
            mute_reg  <= 1'b1;
          end else begin
            wr_en_reg <= write_ok;
            mute_reg  <= 1'b0;
            if (bus.sample_tick) begin
              if (bus.fifo_empty) begin
                state_reg <= ST_PREFILL;
                mute_reg  <= 1'b1;
              end else begin
                rd_en_reg <= 1'b1;
              end
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          flush_reg <= 1'b1;
          mute_reg  <= 1'b1;
        end
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_underrun (
    .clk   (clk),
    .rst   (rst),
    .inc   (underrun_inc),
    .clear (bus.cnt_clear),
    .count (underrun_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_overrun (
    .clk   (clk),
    .rst   (rst),
    .inc   (overrun_inc),
    .clear (bus.cnt_clear),
    .count (overrun_count)
  );

  assign bus.wr_en        = wr_en_reg;
  assign bus.rd_en        = rd_en_reg;
  assign bus.fifo_flush   = flush_reg;
  assign bus.mute         = mute_reg;
  assign bus.state        = state_reg;
  assign bus.underrun_cnt = underrun_count;
  assign bus.overrun_cnt  = overrun_count;
endmodule

// File: doc/playback_scheduler.md
Name: playback_scheduler

Overview:
- Sequences the USB-to-I2S sample path around the stereo FIFO.
- Gates FIFO writes from the receive side and FIFO reads toward the I2S transmitter.
- Holds playback muted until the FIFO reaches a prefill level, then reads one frame per I2S frame tick.
- Detects underrun/overrun, counts them, and re-enters prefill after an underrun so the smoothing buffer never free-runs on a drained FIFO.

Parameters:
LEVEL_W, 10, width of FIFO fill-level input (FIFO depth 2**LEVEL_W frames)
START_LEVEL, 256, fill level (frames) required to leave PREFILL
CNT_W, 16, width of saturating underrun/overrun counters

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
enable  input  1  level; 1 = streaming active (USB alt-setting selected)
cnt_clear  input  1  1-cycle pulse, clears both error counters
sample_valid  input  1  1-cycle pulse, new stereo frame available from USB side
sample_tick  input  1  1-cycle pulse, I2S transmitter needs next frame
fifo_level  input  LEVEL_W  current FIFO occupancy in frames
fifo_full  input  1  FIFO full flag
fifo_empty  input  1  FIFO empty flag
wr_en  output  1  write enable to receive buffer (1-cycle pulse)
rd_en  output  1  read enable to transmit buffer (1-cycle pulse)
fifo_flush  output  1  1-cycle FIFO clear pulse
mute  output  1  1 = I2S output forced to zero
state  output  2  current state encoding
underrun_cnt  output  CNT_W  saturating underrun count
overrun_cnt  output  CNT_W  saturating overrun count

Behaviour:
- All outputs registered. Response appears one cycle after the input event is sampled (latency 1).
- Reset (async, rst=1): state=IDLE, wr_en=0, rd_en=0, fifo_flush=0, mute=1, both counters 0.
- States: IDLE=0, PREFILL=1, PLAY=2. Encoding 3 is illegal; it recovers to IDLE with fifo_flush pulse.
- IDLE:
  - No wr_en/rd_en. mute=1. sample_valid/sample_tick ignored and not counted.
  - enable=1 -> PREFILL next cycle.
- PREFILL:
  - sample_valid & ~fifo_full -> wr_en pulse.
  - sample_tick -> no rd_en.
  - sample_tick & fifo_level>=START_LEVEL & ~fifo_empty -> PLAY, with rd_en pulse issued in the same registered cycle and mute=0 from that cycle.
  - Level reached without a tick: stay in PREFILL. Transitions are frame-aligned only.
- PLAY:
  - sample_valid & ~fifo_full -> wr_en.
  - sample_tick & ~fifo_empty -> rd_en. mute stays 0.
  - sample_tick & fifo_empty -> underrun: no rd_en, underrun_cnt+1, state -> PREFILL, mute=1 in that cycle.
- Overrun, in PREFILL or PLAY: sample_valid & fifo_full -> no wr_en, overrun_cnt+1. Frame dropped; state unchanged.
- Simultaneous sample_valid and sample_tick: both evaluated independently in the same cycle; wr_en and rd_en may both assert.
- Simultaneous underrun and overrun: impossible (full and empty exclusive). If both flags are seen, treat as empty (underrun) and suppress write.
- enable falling, from PREFILL or PLAY:
  - Next cycle: state=IDLE, mute=1, fifo_flush=1 for exactly one cycle.
  - Any sample_valid/sample_tick in that cycle is ignored (no wr_en/rd_en).
  - Counters hold.
- Counters:
  - Saturate at 2**CNT_W-1.
  - cnt_clear has priority over an increment in the same cycle (result 0).
  - Counters are not affected by enable.
- Reset mid-operation: immediate return to reset values. No flush pulse; FIFO reset is owned by the FIFO's own reset.
- wr_en/rd_en never assert for more than one cycle per input pulse. No pulse is generated without a corresponding input pulse.

Decomposition:
- Shared package holds:
  - state typedef/constants (ST_IDLE, ST_PREFILL, ST_PLAY)
  - default START_LEVEL
  - CNT_W
- One sub-module, sat_counter (CNT_W-wide, inc/clear, saturating), instantiated twice for underrun and overrun.
- FSM and enable-edge detect stay in the top.

Test Plan:
1. Reset with START_LEVEL=4: rst=1 then 0 -> state=0, mute=1, counters 0. enable=1 -> state=1 one cycle later.
2. Prefill: 4 sample_valid with fifo_level driven 1..4, then sample_tick -> four wr_en pulses, no rd_en before the tick. On the tick: rd_en=1, mute=0, state=2 next cycle.
3. Underrun: in PLAY, fifo_empty=1 and sample_tick -> rd_en=0, underrun_cnt=1, mute=1, state=1. Refill to 4 then tick -> PLAY resumes.
4. Overrun: fifo_full=1 and 3 sample_valid pulses -> wr_en never asserts, overrun_cnt=3. Same-cycle cnt_clear with a 4th pulse -> overrun_cnt=0.
5. Disable: enable 1->0 in PLAY with simultaneous sample_tick -> next cycle fifo_flush=1 for one cycle, rd_en=0, state=0, mute=1, counters unchanged.
6. Saturation and concurrency:
   - CNT_W=2 override: 5 underruns -> underrun_cnt=3.
   - In PLAY, sample_valid and sample_tick in the same cycle with level 10 -> wr_en=1 and rd_en=1 in the same cycle.
